// File: rtl/ifu_sram_bridge.sv
// ---------------------------------------------------------------------------
// ifu_sram_bridge
//
// Connects the instruction-fetch unit to a synchronous single-port
// instruction SRAM. Fetch requests are decoded for access faults, issued to
// the SRAM, tracked through a fixed-latency tag pipeline and returned
// in order through a small response FIFO. A credit counter covers
// everything in flight plus everything buffered, so a response always has a
// FIFO slot waiting for it and the tag pipeline never stalls.
//
// Ports
//   clk            clock
//   rst            synchronous active-high reset
//   flush          drop every in-flight and buffered response
//   ifu_req_valid  fetch request valid
//   ifu_req_ready  fetch request accepted when valid && ready
//   ifu_req_pc     fetch byte address
//   ifu_rsp_valid  response valid (FIFO head)
//   ifu_rsp_ready  core consumes the head response
//   ifu_rsp_instr  fetched instruction, 0 on an access fault
//   ifu_rsp_err    access fault (misaligned or outside the region)
//   ram_cs         SRAM read enable
//   ram_addr       SRAM word address
//   ram_rdata      SRAM read data, valid RAM_LAT cycles after ram_cs
// ---------------------------------------------------------------------------
module ifu_sram_bridge #(
  parameter int                 PC_SIZE    = 32,
  parameter int                 INSTR_SIZE = 32,
  parameter int                 ADDR_W     = 14,
  parameter logic [PC_SIZE-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                 RAM_LAT    = 1,
  parameter int                 DEPTH      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [PC_SIZE-1:0]    ifu_req_pc,
  output logic                  ifu_rsp_valid,
  input  logic                  ifu_rsp_ready,
  output logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  output logic                  ifu_rsp_err,
  output logic                  ram_cs,
  output logic [ADDR_W-1:0]     ram_addr,
  input  logic [INSTR_SIZE-1:0] ram_rdata
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Credits in use (in flight + buffered) and FIFO occupancy.
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] fill_reg, fill_next;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;

  // Each entry is {err, instr}.
  logic [INSTR_SIZE:0] fifo_mem [DEPTH];

  logic req_err;
  logic acc;
  logic pop;
  logic push;
  logic push_err;
  logic [INSTR_SIZE:0] push_data;
  logic [INSTR_SIZE:0] head;
  logic drop;

  // Reset and flush both discard all state on the same edge.
  assign drop = rst || flush;

  // -------------------------------------------------------------------------
  // Request side
  // -------------------------------------------------------------------------
  assign req_err = (ifu_req_pc[1:0] != 2'b00) ||
                   (ifu_req_pc[PC_SIZE-1:ADDR_W+2] != BASE_ADDR[PC_SIZE-1:ADDR_W+2]);

  // Ready depends only on registered credit state, never on ifu_rsp_ready.
  assign ifu_req_ready = !rst && !flush && (cnt_reg < CW'(DEPTH));
  assign acc           = ifu_req_valid && ifu_req_ready;

  // Faulting requests take a credit and a tag slot but do not touch the SRAM.
  assign ram_cs   = acc && !req_err;
  assign ram_addr = ifu_req_pc[ADDR_W+1:2];

  // -------------------------------------------------------------------------
  // Tag pipeline: one {valid, err} stage per cycle of SRAM latency, so the
  // last stage lines up with ram_rdata for the matching read.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < RAM_LAT; gi++) begin : g_tag
    logic valid_reg;
    logic err_reg;
    logic valid_in;
    logic err_in;

    if (gi == 0) begin : g_first
      assign valid_in = acc;
      assign err_in   = req_err;
    end else begin : g_next
      assign valid_in = g_tag[gi-1].valid_reg;
      assign err_in   = g_tag[gi-1].err_reg;
    end

    always_ff @(posedge clk) begin
      if (drop) begin
        valid_reg <= 1'b0;
      end else begin
        valid_reg <= valid_in;
      end
      err_reg <= err_in;
    end
  end

  assign push      = g_tag[RAM_LAT-1].valid_reg;
  assign push_err  = g_tag[RAM_LAT-1].err_reg;
  assign push_data = {push_err, push_err ? {INSTR_SIZE{1'b0}} : ram_rdata};

  // -------------------------------------------------------------------------
  // Response FIFO
  // -------------------------------------------------------------------------
  assign head          = fifo_mem[rd_ptr_reg];
  assign ifu_rsp_valid = !rst && (fill_reg != '0);
  assign ifu_rsp_instr = ifu_rsp_valid ? head[INSTR_SIZE-1:0] : '0;
  assign ifu_rsp_err   = ifu_rsp_valid ? head[INSTR_SIZE] : 1'b0;
  assign pop           = ifu_rsp_valid && ifu_rsp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= push_data;
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    case ({acc, pop})
      2'b10:   cnt_next = cnt_reg + CW'(1);
      2'b01:   cnt_next = cnt_reg - CW'(1);
      default: cnt_next = cnt_reg;
    endcase
  end

  always_comb begin
    fill_next = fill_reg;
    case ({push, pop})
      2'b10:   fill_next = fill_reg + CW'(1);
      2'b01:   fill_next = fill_reg - CW'(1);
      default: fill_next = fill_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (drop) begin
      cnt_reg    <= '0;
      fill_reg   <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      cnt_reg  <= cnt_next;
      fill_reg <= fill_next;
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifu_sram_bridge.sv
// ---------------------------------------------------------------------------
// tb_ifu_sram_bridge
//
// Two builds side by side: u_lat1 (RAM_LAT=1, DEPTH=3) and u_lat2
// (RAM_LAT=2, DEPTH=4). Each has its own SRAM model. A per-instance monitor
// keeps a queue of expected responses, built from accepted requests, and
// checks ram_cs/ram_addr and every popped response. Directed scenarios run
// on one instance at a time and check timing with hand-computed values.
// ---------------------------------------------------------------------------
module tb_ifu_sram_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  flush, req_valid, rsp_ready;
  logic [31:0] req_pc    [2];
  logic [1:0]  req_ready, rsp_valid, rsp_err, ram_cs;
  logic [31:0] rsp_instr [2];
  logic [13:0] ram_addr  [2];
  logic [31:0] rd1       [2];
  logic [31:0] rd2;

  int checks = 0;
  int passes = 0;

  logic [32:0] q0 [$];
  logic [32:0] q1 [$];

  ifu_sram_bridge #(.RAM_LAT(1), .DEPTH(3)) u_lat1 (
    .clk(clk), .rst(rst), .flush(flush[0]),
    .ifu_req_valid(req_valid[0]), .ifu_req_ready(req_ready[0]), .ifu_req_pc(req_pc[0]),
    .ifu_rsp_valid(rsp_valid[0]), .ifu_rsp_ready(rsp_ready[0]),
    .ifu_rsp_instr(rsp_instr[0]), .ifu_rsp_err(rsp_err[0]),
    .ram_cs(ram_cs[0]), .ram_addr(ram_addr[0]), .ram_rdata(rd1[0])
  );

  ifu_sram_bridge #(.RAM_LAT(2), .DEPTH(4)) u_lat2 (
    .clk(clk), .rst(rst), .flush(flush[1]),
    .ifu_req_valid(req_valid[1]), .ifu_req_ready(req_ready[1]), .ifu_req_pc(req_pc[1]),
    .ifu_rsp_valid(rsp_valid[1]), .ifu_rsp_ready(rsp_ready[1]),
    .ifu_rsp_instr(rsp_instr[1]), .ifu_rsp_err(rsp_err[1]),
    .ram_cs(ram_cs[1]), .ram_addr(ram_addr[1]), .ram_rdata(rd2)
  );

  function automatic logic [31:0] mem_word(input logic [13:0] a);
    return (a == 14'd4) ? 32'h0010_0093 : {a, 4'h5, a};
  endfunction

  function automatic logic err_of(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc[31:16] != 16'h8000);
  endfunction

  // SRAM models; garbage when not read so a misaligned capture shows up.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      rd1[k] <= ram_cs[k] ? mem_word(ram_addr[k]) : 32'hDEAD_BEEF;
    end
    rd2 <= rd1[1];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mon_step(input int k);
    logic e, acc, pop;
    logic [32:0] exp_rsp;
    if (rst) begin
      check($sformatf("rst_out%0d", k),
            {req_ready[k], rsp_valid[k], ram_cs[k], rsp_err[k], rsp_instr[k]}, 64'd0);
      if (k == 0) q0.delete(); else q1.delete();
      return;
    end
    e   = err_of(req_pc[k]);
    acc = req_valid[k] && req_ready[k];
    pop = rsp_valid[k] && rsp_ready[k];
    if (flush[k]) check($sformatf("flush_rdy%0d", k), req_ready[k], 0);
    if (req_valid[k] && !flush[k]) check($sformatf("cs%0d", k), ram_cs[k], acc && !e);
    if (ram_cs[k]) check($sformatf("addr%0d", k), ram_addr[k], req_pc[k][15:2]);
    if (pop) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        check($sformatf("rsp_extra%0d", k), 1, 0);
      end else begin
        exp_rsp = (k == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("rsp%0d", k), {rsp_err[k], rsp_instr[k]}, exp_rsp);
      end
    end
    if (flush[k]) begin
      if (k == 0) q0.delete(); else q1.delete();
    end else if (acc) begin
      exp_rsp = {e, e ? 32'h0 : mem_word(req_pc[k][15:2])};
      if (k == 0) q0.push_back(exp_rsp); else q1.push_back(exp_rsp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    always @(negedge clk) begin
      #2;
      mon_step(gi);
    end
  end

  task automatic run_suite(input int k);
    int lat, depth, nacc, nrsp;
    logic [31:0] p;
    logic [31:0] epc [5];
    logic [4:0] exp_cs, errseq;
    lat   = k + 1;
    depth = k + 3;

    // Idle after reset
    @(negedge clk); #1;
    check($sformatf("rdy_idle%0d", k), req_ready[k], 1);
    check($sformatf("vld_idle%0d", k), rsp_valid[k], 0);

    // Single request, word 4
    @(negedge clk);
    req_valid[k] = 1; req_pc[k] = 32'h8000_0010; rsp_ready[k] = 1;
    #1;
    check($sformatf("single_cs%0d", k), ram_cs[k], 1);
    check($sformatf("single_addr%0d", k), ram_addr[k], 4);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk); req_valid[k] = 0; #1;
      check($sformatf("single_early%0d", k), rsp_valid[k], 0);
    end
    @(negedge clk); #1;
    check($sformatf("single_vld%0d", k), rsp_valid[k], 1);
    check($sformatf("single_instr%0d", k), rsp_instr[k], 32'h0010_0093);
    check($sformatf("single_err%0d", k), rsp_err[k], 0);
    @(negedge clk); #1;
    check($sformatf("single_gone%0d", k), rsp_valid[k], 0);

    // Streaming 16 sequential PCs
    for (int c = 0; c < lat + 18; c++) begin
      @(negedge clk);
      if (c < 16) begin
        req_valid[k] = 1; req_pc[k] = 32'h8000_0100 + 32'(4 * c);
      end else begin
        req_valid[k] = 0;
      end
      #1;
      if (c < 16) check($sformatf("stream_rdy%0d", k), req_ready[k], 1);
      check($sformatf("stream_vld%0d_c%0d", k, c), rsp_valid[k],
            (c >= lat + 1) && (c < lat + 17));
    end

    // Stall / release rounds across pointer wrap
    p = 32'h8000_0200;
    for (int r = 0; r < 10; r++) begin
      nacc = 0;
      for (int c = 0; c < depth + lat + 2; c++) begin
        @(negedge clk);
        rsp_ready[k] = 0; req_valid[k] = 1; req_pc[k] = p;
        #1;
        if (req_ready[k]) begin
          nacc++;
          p += 4;
        end
      end
      check($sformatf("stall_acc%0d_r%0d", k, r), nacc, depth);
      check($sformatf("stall_rdy%0d_r%0d", k, r), req_ready[k], 0);
      nrsp = 0;
      for (int c = 0; c < depth + 2; c++) begin
        @(negedge clk);
        req_valid[k] = 0; rsp_ready[k] = 1;
        #1;
        if (rsp_valid[k]) nrsp++;
      end
      check($sformatf("drain_cnt%0d_r%0d", k, r), nrsp, depth);
      check($sformatf("drain_rdy%0d_r%0d", k, r), req_ready[k], 1);
    end

    // Faulting requests interleaved with good ones
    epc[0] = 32'h8000_0020; epc[1] = 32'h8000_0002; epc[2] = 32'h8000_0024;
    epc[3] = 32'h7FFF_FFFC; epc[4] = 32'h8000_0028;
    exp_cs = 5'b10101;
    errseq = '0;
    nrsp   = 0;
    for (int c = 0; c < lat + 7; c++) begin
      @(negedge clk);
      rsp_ready[k] = 1;
      if (c < 5) begin
        req_valid[k] = 1; req_pc[k] = epc[c];
      end else begin
        req_valid[k] = 0;
      end
      #1;
      if (c < 5) check($sformatf("err_cs%0d_%0d", k, c), ram_cs[k], exp_cs[c]);
      if (rsp_valid[k]) begin
        errseq = {errseq[3:0], rsp_err[k]};
        nrsp++;
        if (rsp_err[k]) check($sformatf("err_instr%0d", k), rsp_instr[k], 0);
      end
    end
    check($sformatf("err_order%0d", k), errseq, 5'b01010);
    check($sformatf("err_nrsp%0d", k), nrsp, 5);

    // Flush with entries buffered and in flight
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rsp_ready[k] = 0; req_valid[k] = 1; req_pc[k] = 32'h8000_0300 + 32'(4 * c);
    end
    @(negedge clk);
    req_valid[k] = 0; flush[k] = 1;
    #1;
    check($sformatf("flush_rdy_low%0d", k), req_ready[k], 0);
    check($sformatf("flush_had_rsp%0d", k), rsp_valid[k], 1);
    @(negedge clk);
    flush[k] = 0;
    #1;
    check($sformatf("flush_vld%0d", k), rsp_valid[k], 0);
    check($sformatf("flush_cnt%0d", k), (k == 0) ? u_lat1.cnt_reg : u_lat2.cnt_reg, 0);
    rsp_ready[k] = 1;
    for (int c = 0; c < lat + 3; c++) begin
      @(negedge clk); #1;
      check($sformatf("flush_quiet%0d", k), rsp_valid[k], 0);
    end
    @(negedge clk);
    req_valid[k] = 1; req_pc[k] = 32'h8000_0010;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk); req_valid[k] = 0;
    end
    @(negedge clk); #1;
    check($sformatf("post_flush_vld%0d", k), rsp_valid[k], 1);
    check($sformatf("post_flush_instr%0d", k), rsp_instr[k], 32'h0010_0093);

    @(negedge clk);
    req_valid[k] = 0; rsp_ready[k] = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1; flush = '0; req_valid = '0; rsp_ready = '0;
    req_pc[0] = '0; req_pc[1] = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    run_suite(0);
    run_suite(1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ifu_sram_bridge.md
# ifu_sram_bridge

Instruction-fetch memory bridge on the core's IFU memory interface. It accepts fetch requests from the core (`ifu_req_*`), reads a synchronous single-port instruction SRAM with fixed latency, and returns in-order responses (`ifu_rsp_*`) through a response buffer. Credit-based flow control guarantees that no response is ever lost when the core stalls `ifu_rsp_ready`. A flush input lets the fetch unit discard stale fetches after a redirect.

## Interface
- `PC_SIZE`, 32: request address width.
- `INSTR_SIZE`, 32: instruction/SRAM data width.
- `ADDR_W`, 14: SRAM word-address width. Region size is 4·2^ADDR_W bytes.
- `BASE_ADDR`, 32'h8000_0000: region base. Must be aligned to the region size.
- `RAM_LAT`, 1: SRAM read latency in cycles. Legal values are 1 and 2.
- `DEPTH`, 3: credit count and response FIFO depth. Must be ≥ RAM_LAT+2.
- `clk`  in  1  clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  discard all in-flight and buffered responses.
- `ifu_req_valid`  in  1  request valid.
- `ifu_req_ready`  out  1  request accepted when valid && ready.
- `ifu_req_pc`  in  PC_SIZE  fetch address.
- `ifu_rsp_valid`  out  1  response valid.
- `ifu_rsp_ready`  in  1  core consumes response.
- `ifu_rsp_instr`  out  INSTR_SIZE  fetched instruction; 0 on error.
- `ifu_rsp_err`  out  1  access fault (misaligned or out of region).
- `ram_cs`  out  1  SRAM read enable.
- `ram_addr`  out  ADDR_W  SRAM word address.
- `ram_rdata`  in  INSTR_SIZE  SRAM read data, valid RAM_LAT cycles after `ram_cs`.

## Operation
- Accept condition: `acc = ifu_req_valid && ifu_req_ready`.
- Request ready: `ifu_req_ready = !rst && !flush && (cnt < DEPTH)`.
  - `cnt` counts entries that are in flight plus entries buffered in the FIFO.
  - `ifu_req_ready` has no combinational path from `ifu_rsp_ready`.
- Error decode, combinational on the request:
  - `err = (pc[1:0] != 0) || (pc[PC_SIZE-1:ADDR_W+2] != BASE_ADDR[PC_SIZE-1:ADDR_W+2])`.
- On `acc && !err`: `ram_cs = 1` and `ram_addr = pc[ADDR_W+1:2]` in the same cycle.
- On `acc && err`: `ram_cs = 0`. The request still enters the tag pipeline with its err flag set, so response ordering is preserved.
- Tag pipeline: RAM_LAT stages, each holding {valid, err}, advancing every cycle with no stall. The pipeline never needs to stall because credits guarantee FIFO space.
- When a valid tag exits the pipeline, push {err ? 0 : ram_rdata, err} into the FIFO.
- FIFO: DEPTH entries with circular read and write pointers that wrap modulo DEPTH.
  - `ifu_rsp_valid = !empty`. Output data comes from the head entry.
  - Pop on `ifu_rsp_valid && ifu_rsp_ready`.
- Counter update: `cnt` next = `cnt + acc − pop`.
  - Simultaneous accept and pop leave `cnt` unchanged.
  - `cnt` never exceeds DEPTH and never underflows.
- Flush, effective on the same clock edge:
  - Clear all tag-pipeline valids, FIFO pointers, and `cnt`.
  - No request is accepted in the flush cycle, because ready is forced low.
  - A pop in the flush cycle counts as a completed handshake; its entry is discarded along with the rest.
  - SRAM data from reads issued before the flush is ignored.

## Timing
- Reset: on the `rst` edge, `cnt = 0`, FIFO is empty, and tag valids are 0.
  - While `rst` is high: `ifu_req_ready = 0`, `ifu_rsp_valid = 0`, `ram_cs = 0`, `ifu_rsp_instr = 0`, `ifu_rsp_err = 0`.
  - Reset asserted mid-operation drops everything, the same as flush.
- Latency: a request accepted in cycle T produces `ifu_rsp_valid` in cycle T+RAM_LAT+1 at the earliest, when the FIFO was empty and nothing is ahead of it.
- Throughput: with DEPTH ≥ RAM_LAT+2 and `ifu_rsp_ready` held high, the bridge sustains 1 request/cycle and 1 response/cycle.
- Backpressure: with `ifu_rsp_ready` low, `ifu_req_ready` deasserts once `cnt == DEPTH`.
  - Responses are held stable while valid and not popped.
- Responses are returned strictly in request order, error responses included.

## Test plan
- Reset, then a single request with pc=0x8000_0010 and SRAM word 4 = 0x0010_0093:
  - `ram_cs` and `ram_addr` = 4 in cycle T.
  - `ifu_rsp_valid` in cycle T+2 with instr 0x0010_0093 and err 0.
- Back-to-back streaming of 16 sequential PCs with `ifu_rsp_ready` = 1:
  - `ifu_req_ready` never drops.
  - 16 in-order responses on 16 consecutive cycles.
- Stall: `ifu_rsp_ready` = 0 with continuous requests:
  - Exactly 3 requests are accepted, then `ifu_req_ready` = 0.
  - Raising `ifu_rsp_ready` drains 3 responses in order and ready returns.
  - No responses are lost or duplicated across FIFO pointer wrap (run 10 stall/release rounds).
- Errors: pc=0x8000_0002 and pc=0x7FFF_FFFC, interleaved with good PCs:
  - Each error gets `ram_cs` = 0 and a response with err 1 and instr 0.
  - Ordering is preserved.
- Flush with 3 outstanding entries (FIFO partly full, one in flight):
  - Next cycle: `ifu_rsp_valid` = 0 and `cnt` = 0.
  - The in-flight SRAM data is not delivered.
  - A new request after the flush returns correct data.
- RAM_LAT=2, DEPTH=4 build: repeat the streaming and stall scenarios.
  - First response at T+3.
  - 4 accepts before stall.
